// File: rtl/fp16_mul_seq.sv
// Sequenced binary16 multiplier: classify, normalize subnormals one bit per
// cycle, multiply significands, truncate, and hold the result under back-pressure.
module fp16_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        inf,
  output logic        zero,
  output logic        nan
);

  typedef enum logic [2:0] {IDLE, CHECK, NORM, MUL, DONE} state_t;

  state_t             state_q;
  logic [15:0]        a_q, b_q;
  logic               sign_q;
  logic [10:0]        sig_a_q, sig_b_q;
  logic signed [6:0]  e_a_q, e_b_q;
  logic [15:0]        product_q;
  logic               inf_q, zero_q, nan_q, out_valid_q;

  logic               sign_c;
  logic               a_nan, a_inf, a_zero, a_sub;
  logic               b_nan, b_inf, b_zero, b_sub;
  logic [10:0]        sig_a_init, sig_b_init;
  logic signed [6:0]  e_a_init, e_b_init;
  logic [10:0]        sig_a_d, sig_b_d;
  logic signed [6:0]  e_a_d, e_b_d;
  logic [21:0]        p;
  logic [9:0]         mant;
  logic signed [7:0]  e_sum, e_biased;
  logic               unused_bits;

  always_comb begin
    sign_c = a_q[15] ^ b_q[15];

    a_nan  = (&a_q[14:10]) && (|a_q[9:0]);
    a_inf  = (&a_q[14:10]) && !(|a_q[9:0]);
    a_zero = (a_q[14:10] == 5'd0) && (a_q[9:0] == 10'd0);
    a_sub  = (a_q[14:10] == 5'd0) && (a_q[9:0] != 10'd0);
    b_nan  = (&b_q[14:10]) && (|b_q[9:0]);
    b_inf  = (&b_q[14:10]) && !(|b_q[9:0]);
    b_zero = (b_q[14:10] == 5'd0) && (b_q[9:0] == 10'd0);
    b_sub  = (b_q[14:10] == 5'd0) && (b_q[9:0] != 10'd0);

    sig_a_init = {~a_sub, a_q[9:0]};
    sig_b_init = {~b_sub, b_q[9:0]};
    e_a_init   = a_sub ? -7'sd14 : ($signed({2'b00, a_q[14:10]}) - 7'sd15);
    e_b_init   = b_sub ? -7'sd14 : ($signed({2'b00, b_q[14:10]}) - 7'sd15);

    sig_a_d = sig_a_q[10] ? sig_a_q : {sig_a_q[9:0], 1'b0};
    sig_b_d = sig_b_q[10] ? sig_b_q : {sig_b_q[9:0], 1'b0};
    e_a_d   = sig_a_q[10] ? e_a_q : (e_a_q - 7'sd1);
    e_b_d   = sig_b_q[10] ? e_b_q : (e_b_q - 7'sd1);

    // Both significands are in [1,2), so the product is in [1,4): bit 21 or bit 20 leads.
    p        = {11'd0, sig_a_q} * {11'd0, sig_b_q};
    mant     = p[21] ? p[20:11] : p[19:10];
    e_sum    = {e_a_q[6], e_a_q} + {e_b_q[6], e_b_q} + {7'd0, p[21]};
    e_biased = e_sum + 8'sd15;

    unused_bits = ^{p[9:0], e_biased[7:5]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      sig_a_q     <= '0;
      sig_b_q     <= '0;
      e_a_q       <= '0;
      e_b_q       <= '0;
      product_q   <= '0;
      inf_q       <= 1'b0;
      zero_q      <= 1'b0;
      nan_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          sign_q <= sign_c;
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            product_q   <= 16'h7E00;
            {inf_q, zero_q, nan_q} <= 3'b001;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (a_inf || b_inf) begin
            product_q   <= {sign_c, 5'h1F, 10'h0};
            {inf_q, zero_q, nan_q} <= 3'b100;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (a_zero || b_zero) begin
            product_q   <= {sign_c, 15'h0};
            {inf_q, zero_q, nan_q} <= 3'b010;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sig_a_q <= sig_a_init;
            sig_b_q <= sig_b_init;
            e_a_q   <= e_a_init;
            e_b_q   <= e_b_init;
            state_q <= (sig_a_init[10] && sig_b_init[10]) ? MUL : NORM;
          end
        end
        NORM: begin
          sig_a_q <= sig_a_d;
          sig_b_q <= sig_b_d;
          e_a_q   <= e_a_d;
          e_b_q   <= e_b_d;
          if (sig_a_d[10] && sig_b_d[10]) state_q <= MUL;
        end
        MUL: begin
          if (e_sum > 8'sd15) begin
            product_q <= {sign_q, 5'h1F, 10'h0};
            {inf_q, zero_q, nan_q} <= 3'b100;
          end else if (e_sum < -8'sd14) begin
            product_q <= {sign_q, 15'h0};
            {inf_q, zero_q, nan_q} <= 3'b010;
          end else begin
            product_q <= {sign_q, e_biased[4:0], mant};
            {inf_q, zero_q, nan_q} <= 3'b000;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign inf       = inf_q;
  assign zero      = zero_q;
  assign nan       = nan_q;

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Bench for fp16_mul_seq: vector table with hand-derived results and latencies,
// plus back-pressure and mid-operation reset sequences.
module tb_fp16_mul_seq;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, product;
  logic        inf, zero, nan;

  fp16_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .inf(inf), .zero(zero), .nan(nan)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [2:0]  f;    // {inf, zero, nan}
    int unsigned lat;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [2:0]  f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges from the accepting edge to out_valid, then checks and releases the result.
  task automatic wait_result(input int unsigned elat);
    int unsigned lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    if (!out_valid) begin
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk("product", {16'd0, product}, {16'd0, e.p});
    chk("flags", {29'd0, inf, zero, nan}, {29'd0, e.f});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] ep, input logic [2:0] ef, input int unsigned elat);
    int unsigned w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom();
    sb.push_back('{ep, ef});
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    wait_result(elat);
  endtask

  initial begin
    logic seen_valid;
    exp_t e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

    vecs.push_back('{16'hC000, 16'h3E00, 16'hC200, 3'b000, 2});
    vecs.push_back('{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100, 2});
    vecs.push_back('{16'h0400, 16'h0400, 16'h0000, 3'b010, 2});
    vecs.push_back('{16'h0001, 16'h6400, 16'h0400, 3'b000, 12});
    vecs.push_back('{16'h7C00, 16'h8000, 16'h7E00, 3'b001, 1});
    vecs.push_back('{16'hFC00, 16'h3C00, 16'hFC00, 3'b100, 1});
    vecs.push_back('{16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 2});
    vecs.push_back('{16'h3E00, 16'h3E00, 16'h4080, 3'b000, 2});
    vecs.push_back('{16'h3C01, 16'h3C01, 16'h3C02, 3'b000, 2});
    vecs.push_back('{16'h0200, 16'h4000, 16'h0400, 3'b000, 3});
    vecs.push_back('{16'h4000, 16'h7800, 16'h7C00, 3'b100, 2});
    vecs.push_back('{16'h7E00, 16'h3C00, 16'h7E00, 3'b001, 1});
    vecs.push_back('{16'h0000, 16'h7C00, 16'h7E00, 3'b001, 1});
    vecs.push_back('{16'h8000, 16'h3C00, 16'h8000, 3'b010, 1});
    vecs.push_back('{16'h0400, 16'h3C00, 16'h0400, 3'b000, 2});
    vecs.push_back('{16'h0400, 16'h3BFF, 16'h0000, 3'b010, 2});
    vecs.push_back('{16'h0001, 16'h0001, 16'h0000, 3'b010, 12});
    vecs.push_back('{16'h8001, 16'h0200, 16'h8000, 3'b010, 12});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_flags", {29'd0, inf, zero, nan}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].f, vecs[i].lat);

    // Back-pressure with the next pair already waiting on in_valid
    a = 16'hC000; b = 16'h3E00; in_valid = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{16'hC200, 3'b000});
    a = 16'h3C00; b = 16'h3C00;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {12'd0, out_valid, in_ready, product, inf, zero, nan},
          {12'd0, 1'b1, 1'b0, e.p, e.f});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_transfer", {30'd0, in_ready, out_valid}, 32'b10);
    sb.push_back('{16'h3C00, 3'b000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accept", {31'd0, in_ready}, 32'd0);
    wait_result(2);

    // Reset during NORM discards the operation
    a = 16'h0001; b = 16'h3C00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_low", {30'd0, in_ready, out_valid}, 32'b00);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_high", {31'd0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_valid", {31'd0, seen_valid}, 32'd0);
    run_op(16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_mul_seq.md
# fp16_mul_seq

Sequenced IEEE 754 half-precision multiplier with valid/ready handshakes on both sides. It captures an operand pair, classifies special values, and normalizes subnormal operands one bit per cycle. It then forms the 11x11 mantissa product and registers a packed result with inf/zero/nan flags. It sits between the operand-issue logic and the writeback path, and replaces direct use of the combinational multiply datapath wherever subnormal inputs or back-pressure must be handled.

## Interface
- No parameters. Widths are fixed by binary16: sign 1, exponent 5, mantissa 10, bias 15.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair on a/b is valid.
- in_ready  out  1  block can accept. High only in IDLE with rst low.
- a  in  16  operand A, binary16.
- b  in  16  operand B, binary16.
- out_valid  out  1  product and flags are valid.
- out_ready  in  1  consumer accepts the result.
- product  out  16  binary16 result, registered.
- inf  out  1  result is ±infinity (overflow or infinite operand).
- zero  out  1  result is ±0 (zero operand or underflow flush).
- nan  out  1  result is canonical NaN.

## Operation
- States: IDLE, CHECK, NORM, MUL, DONE.
- IDLE: in_ready=1. If in_valid, capture a and b at the edge and go to CHECK.
- CHECK (1 cycle): sign = a[15]^b[15]. Classify each operand: exp=31 with mant≠0 is NaN; exp=31 with mant=0 is inf; exp=0 with mant=0 is zero; exp=0 with mant≠0 is subnormal; otherwise normal.
  - Either NaN, or inf×zero: product=16'h7E00, nan=1, go to DONE.
  - Else either inf: product={sign,5'h1F,10'h0}, inf=1, go to DONE.
  - Else either zero: product={sign,15'h0}, zero=1, go to DONE.
  - Else load the significands. Normal: {1,mant}, with e = exp−15 held in a 7-bit signed register. Subnormal: {0,mant}, with e = −14.
  - Go to NORM if any significand bit10 is 0, else to MUL.
- NORM (1 cycle per shift): each operand whose significand bit10 is 0 shifts left by 1 and decrements its e. Both operands shift in the same cycle when both need it. Go to MUL when both bit10 are 1. Maximum 10 cycles.
- MUL (1 cycle): p[21:0] = sigA×sigB and E = eA+eB.
  - If p[21]: mant=p[20:11], E=E+1. Else mant=p[19:10].
  - Rounding is truncation.
  - Then: if E>15, product={sign,5'h1F,10'h0} and inf=1. Else if E<−14, product={sign,15'h0} and zero=1; no subnormal results are produced. Else product={sign,E+15,mant}.
  - Go to DONE.
- DONE: out_valid=1. product and flags are stable until the transfer completes. If out_ready, go to IDLE at the edge.
- At most one flag is high. All flags are 0 for a finite nonzero result.

## Timing
- Reset: state=IDLE, out_valid=0, product=16'h0000, inf=zero=nan=0, and in_ready=0 while rst is high. Reset in any state aborts the operation and discards the result; no out_valid follows.
- Latency is counted in edges from the accepting edge to out_valid high:
  - special case: 1.
  - normal×normal: 2.
  - with k normalization shifts: 2+k, where k = max leading-zero shifts of the two operands (≤10).
- Throughput: one operation in flight. in_ready=0 from the accepting edge until the edge that completes the output transfer.
  - The earliest next accept is the edge after DONE exits, so back-to-back normals give one result every 4 edges.
- out_valid must not drop, and product/flags must not change, while out_ready=0.
- a and b are don't-care outside the accepting edge.

## Test plan
- Accept a=16'hC000, b=16'h3E00 → product=16'hC200, all flags 0, out_valid 2 edges after accept, released on the first edge with out_ready=1.
- a=16'h7BFF, b=16'h7BFF → product=16'h7C00, inf=1. a=16'h0400, b=16'h0400 → product=16'h0000, zero=1.
- a=16'h0001, b=16'h6400 → product=16'h0400, flags 0, 10 NORM cycles, out_valid 12 edges after accept.
- a=16'h7C00, b=16'h8000 → product=16'h7E00, nan=1, latency 1. a=16'hFC00, b=16'h3C00 → product=16'hFC00, inf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid. Require product and flags stable and in_ready=0 throughout, with in_valid held high. After release, the next pair is accepted one edge later.
- Assert rst for 1 cycle during NORM on a=16'h0001 → IDLE with in_ready=1 after rst drops, out_valid never asserted, and a new pair 3C00×3C00 → 16'h3C00.
